// File: rtl/seg7_pkg.sv
// Shared constants and hex decode for the 4-digit 7-segment driver.
// Segments are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [6:0] hex_seg(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] an_sel(
    input logic [1:0] d
  );
    logic [3:0] a;
    a = AN_OFF;
    unique case (d)
      2'd0: a = AN_DIG0;
      2'd1: a = AN_DIG1;
      2'd2: a = AN_DIG2;
      2'd3: a = AN_DIG3;
      default: a = AN_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seg7_display_driver_if.sv
// Display-side bundle: anodes, segments, decimal point, flag LEDs.
// master = driver, slave = panel / observer.
interface seg7_display_driver_if;

  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [4:0] led;

  modport master (
    output an,
    output seg,
    output dp,
    output led
  );

  modport slave (
    input an,
    input seg,
    input dp,
    input led
  );

endinterface

// File: rtl/seg7_display_driver_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decode.
// Ports: nibble (in, 4), seg (out, 7, {g..a}).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_seg(nibble);
  end

endmodule

// File: rtl/seg7_display_driver.sv
// 4-digit multiplexed 7-seg driver with per-frame snapshot,
// leading-zero blanking, blinking flag dp and flag LEDs.
// Ports: clk, reset (async high), value[15:0], flags[4:0],
// blank_lz, disp (an/seg/dp/led, master modport).
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  input  logic [4:0]            flags,
  input  logic                  blank_lz,
  seg7_display_driver_if.master disp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be >= 1");
  end

  logic [PW-1:0] ps_q;
  logic [1:0]    dig_q;
  logic [15:0]   snap_v;
  logic [4:0]    snap_f;
  logic [FW-1:0] frm_q;
  logic          blink_q;
  logic          upd_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          tick;
  logic          frame_start;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          lz;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign tick        = (ps_q == PS_MAX);
  assign frame_start = tick && (dig_q == 2'd3);

  // Scan timing: prescaler, digit index, frame/blink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q    <= '0;
      dig_q   <= 2'd3;
      snap_v  <= '0;
      snap_f  <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= tick;
      if (tick) begin
        ps_q  <= '0;
        dig_q <= dig_q + 2'd1;
      end else begin
        ps_q <= ps_q + 1'b1;
      end
      if (frame_start) begin
        snap_v <= value;
        snap_f <= flags;
        if (frm_q == FR_MAX) begin
          frm_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          frm_q <= frm_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nibble = snap_v[3:0];
    unique case (dig_q)
      2'd0: nibble = snap_v[3:0];
      2'd1: nibble = snap_v[7:4];
      2'd2: nibble = snap_v[11:8];
      2'd3: nibble = snap_v[15:12];
      default: nibble = snap_v[3:0];
    endcase
  end

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // A digit is a leading zero when it and everything above it is 0.
  always_comb begin
    lz = 1'b0;
    unique case (dig_q)
      2'd0: lz = 1'b0;
      2'd1: lz = (snap_v[15:4] == '0);
      2'd2: lz = (snap_v[15:8] == '0);
      2'd3: lz = (snap_v[15:12] == '0);
      default: lz = 1'b0;
    endcase
    lz = lz && blank_lz;
  end

  always_comb begin
    an_d  = an_sel(dig_q);
    seg_d = seg_dec;
    dp_d  = 1'b1;
    if (lz) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else if (dig_q == 2'd3 && snap_f != '0 && blink_q) begin
      dp_d = 1'b0;
    end
  end

  // Outputs follow the tick by one cycle, so they see the new
  // index and any snapshot taken on the frame-start tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else if (upd_q) begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;
  assign disp.led = snap_f;

endmodule
